// File: rtl/pipe_execute_gen.sv
// Y86-64 execute stage with E->M pipeline register, width-generic ALU, CC register
// and a multi-cycle shift-add MULQ (OPq ifun 4) that holds the front end via e_busy.
module pipe_execute_gen #(
    parameter int XLEN    = 64,
    parameter int MUL_LAT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      E_stat,
    input  logic [3:0]      E_icode,
    input  logic [3:0]      E_ifun,
    input  logic [XLEN-1:0] E_valA,
    input  logic [XLEN-1:0] E_valB,
    input  logic [XLEN-1:0] E_valC,
    input  logic [3:0]      E_dstE,
    input  logic [3:0]      E_dstM,
    input  logic            set_CC,
    input  logic [3:0]      m_stat,
    input  logic [3:0]      W_stat,
    input  logic            M_bubble,
    output logic            e_busy,
    output logic            e_Cnd,
    output logic [XLEN-1:0] e_valE,
    output logic [3:0]      e_dstE,
    output logic [3:0]      M_stat,
    output logic [3:0]      M_icode,
    output logic            M_Cnd,
    output logic [XLEN-1:0] M_valE,
    output logic [XLEN-1:0] M_valA,
    output logic [3:0]      M_dstE,
    output logic [3:0]      M_dstM,
    output logic [2:0]      CC
);
    localparam logic [3:0] S_AOK = 4'd1, S_INS = 4'd4, R_NONE = 4'hF;
    localparam logic [3:0] I_NOP = 4'h1, I_RRMOV = 4'h2, I_IRMOV = 4'h3, I_RMMOV = 4'h4,
                           I_MRMOV = 4'h5, I_OPQ = 4'h6, I_CALL = 4'h8, I_RET = 4'h9,
                           I_PUSH = 4'hA, I_POP = 4'hB;
    localparam int CW    = XLEN / MUL_LAT;
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [XLEN-1:0]  EIGHT    = XLEN'(8);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_cur;
    logic [XLEN-1:0]     a_q, b_q, mul_a, mul_b, b_sh;
    logic [2*XLEN-1:0]   acc_q, a_sx, part, acc_sum, mul_full;
    logic                mul_of;
    logic [XLEN-1:0]     alu_a, alu_b, alu_res;
    logic [3:0]          fn, e_stat;
    logic                alu_of, start, last, stat_ok, alu_cc, cc_we;
    logic                zf, sf, of, lt;

    // ALU operand and function selection
    always_comb begin
        alu_a = '0;
        case (E_icode)
            I_RRMOV, I_OPQ:           alu_a = E_valA;
            I_IRMOV, I_RMMOV, I_MRMOV: alu_a = E_valC;
            I_CALL, I_PUSH:           alu_a = -EIGHT;
            I_RET, I_POP:             alu_a = EIGHT;
            default:                  alu_a = '0;
        endcase
        alu_b = (E_icode == I_RRMOV || E_icode == I_IRMOV) ? '0 : E_valB;
        fn    = (E_icode == I_OPQ) ? E_ifun : 4'd0;
        alu_res = '0;
        alu_of  = 1'b0;
        case (fn)
            4'd0: begin
                alu_res = alu_a + alu_b;
                alu_of  = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (alu_res[XLEN-1] != alu_a[XLEN-1]);
            end
            4'd1: begin
                alu_res = alu_b - alu_a;
                alu_of  = (alu_b[XLEN-1] != alu_a[XLEN-1]) && (alu_res[XLEN-1] != alu_b[XLEN-1]);
            end
            4'd2:    alu_res = alu_a & alu_b;
            4'd3:    alu_res = alu_a ^ alu_b;
            default: alu_res = '0;
        endcase
    end

    // One CW-bit chunk of B per cycle; the MSB correction turns the unsigned
    // accumulation into a signed 2*XLEN product so OF can be derived exactly.
    always_comb begin
        mul_a    = (state_q == S_MUL) ? a_q : E_valA;
        mul_b    = (state_q == S_MUL) ? b_q : E_valB;
        cnt_cur  = (state_q == S_MUL) ? cnt_q : '0;
        a_sx     = {{XLEN{mul_a[XLEN-1]}}, mul_a};
        b_sh     = mul_b >> (int'(cnt_cur) * CW);
        part     = a_sx * {{(2*XLEN-CW){1'b0}}, b_sh[CW-1:0]};
        acc_sum  = ((state_q == S_MUL) ? acc_q : '0) + (part << (int'(cnt_cur) * CW));
        mul_full = acc_sum - (mul_b[XLEN-1] ? {mul_a, {XLEN{1'b0}}} : '0);
        mul_of   = mul_full[2*XLEN-1:XLEN] != {XLEN{mul_full[XLEN-1]}};
    end

    assign start   = (state_q == S_IDLE) && (E_icode == I_OPQ) && (E_ifun == 4'd4) && (E_stat == S_AOK);
    assign last    = ((state_q == S_MUL) && (cnt_q == LAST_CNT)) || (start && MUL_LAT == 1);
    assign stat_ok = (E_stat == S_AOK) && (m_stat == S_AOK) && (W_stat == S_AOK);
    assign alu_cc  = (state_q == S_IDLE) && (E_icode == I_OPQ) && (E_ifun < 4'd4);
    assign cc_we   = set_CC && stat_ok && (E_icode == I_OPQ) &&
                     (alu_cc || (last && !((state_q == S_MUL) && M_bubble)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        e_busy  = 1'b0;
        case (state_q)
            S_IDLE: if (start && !last) begin
                e_busy = 1'b1;
                cnt_d  = CNT_W'(1);
                if (!M_bubble) state_d = S_MUL;
            end
            S_MUL: begin
                e_busy = !last;
                if (M_bubble || last) state_d = S_IDLE;
                else                  cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign zf = CC[2];
    assign sf = CC[1];
    assign of = CC[0];
    assign lt = sf ^ of;

    always_comb begin
        case (E_ifun)
            4'd0:    e_Cnd = 1'b1;
            4'd1:    e_Cnd = lt | zf;
            4'd2:    e_Cnd = lt;
            4'd3:    e_Cnd = zf;
            4'd4:    e_Cnd = !zf;
            4'd5:    e_Cnd = !lt;
            4'd6:    e_Cnd = !lt && !zf;
            default: e_Cnd = 1'b0;
        endcase
    end

    assign e_valE = ((state_q == S_MUL) || (E_icode == I_OPQ && E_ifun == 4'd4))
                    ? mul_full[XLEN-1:0] : alu_res;
    assign e_dstE = (E_icode == I_RRMOV && !e_Cnd) ? R_NONE : E_dstE;
    assign e_stat = (E_stat == S_AOK && E_icode == I_OPQ && E_ifun > 4'd4) ? S_INS : E_stat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_sum;
            if (state_q == S_IDLE) begin
                a_q <= E_valA;
                b_q <= E_valB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            CC <= 3'b100;
        end else if (cc_we) begin
            if (E_ifun == 4'd4)
                CC <= {mul_full[XLEN-1:0] == '0, mul_full[XLEN-1], mul_of};
            else
                CC <= {alu_res == '0, alu_res[XLEN-1], alu_of};
        end
    end

    // A stalled MULQ and an explicit bubble both present a nop to M
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            M_stat  <= S_AOK;
            M_icode <= I_NOP;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= R_NONE;
            M_dstM  <= R_NONE;
        end else if (M_bubble || e_busy) begin
            M_stat  <= S_AOK;
            M_icode <= I_NOP;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= R_NONE;
            M_dstM  <= R_NONE;
        end else begin
            M_stat  <= e_stat;
            M_icode <= E_icode;
            M_Cnd   <= e_Cnd;
            M_valE  <= e_valE;
            M_valA  <= E_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
        end
    end
endmodule

// File: tb/tb_pipe_execute_gen.sv
// Bench for pipe_execute_gen: a 64-bit/MUL_LAT=4 instance driven from a vector
// table with a result queue, plus a 16-bit/MUL_LAT=2 instance for narrow corners.
module tb_pipe_execute_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 64-bit instance
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, m_stat, W_stat;
    logic [63:0] E_valA, E_valB, E_valC;
    logic        set_CC, M_bubble;
    logic        e_busy, e_Cnd, M_Cnd;
    logic [63:0] e_valE, M_valE, M_valA;
    logic [3:0]  e_dstE, M_stat, M_icode, M_dstE, M_dstM;
    logic [2:0]  CC;

    pipe_execute_gen #(.XLEN(64), .MUL_LAT(4)) u64 (
        .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .set_CC(set_CC), .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
        .e_busy(e_busy), .e_Cnd(e_Cnd), .e_valE(e_valE), .e_dstE(e_dstE),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .CC(CC));

    // 16-bit instance
    logic [3:0]  s_icode, s_ifun;
    logic [15:0] s_valA, s_valB, s_valC;
    logic        s_set_CC, s_bubble;
    logic        s_e_busy, s_e_Cnd, s_M_Cnd;
    logic [15:0] s_e_valE, s_M_valE, s_M_valA;
    logic [3:0]  s_e_dstE, s_M_stat, s_M_icode, s_M_dstE, s_M_dstM;
    logic [2:0]  s_CC;
    logic [3:0]  aok = 4'd1;
    logic [3:0]  s_dst = 4'd2;

    pipe_execute_gen #(.XLEN(16), .MUL_LAT(2)) u16 (
        .clk(clk), .rst_n(rst_n), .E_stat(aok), .E_icode(s_icode), .E_ifun(s_ifun),
        .E_valA(s_valA), .E_valB(s_valB), .E_valC(s_valC), .E_dstE(s_dst), .E_dstM(s_dst),
        .set_CC(s_set_CC), .m_stat(aok), .W_stat(aok), .M_bubble(s_bubble),
        .e_busy(s_e_busy), .e_Cnd(s_e_Cnd), .e_valE(s_e_valE), .e_dstE(s_e_dstE),
        .M_stat(s_M_stat), .M_icode(s_M_icode), .M_Cnd(s_M_Cnd), .M_valE(s_M_valE),
        .M_valA(s_M_valA), .M_dstE(s_M_dstE), .M_dstM(s_M_dstM), .CC(s_CC));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  stat, icode, ifun;
        logic [63:0] va, vb, vc;
        logic [3:0]  dste;
        logic        setcc;
        logic [3:0]  mstat;
        logic        chk_val;
        logic [63:0] x_vale;
        logic        x_cnd;
        logic [3:0]  x_dste, x_mstat;
        logic [2:0]  x_cc;
    } vec_t;

    typedef struct {
        logic [3:0]  stat, icode, dste;
        logic        chk_val, cnd;
        logic [63:0] vale;
        logic [2:0]  cc;
    } m_exp_t;

    m_exp_t sbq[$];
    vec_t   vt[17];

    task automatic set_nop();
        E_stat = 4'd1; E_icode = 4'h1; E_ifun = 4'd0; E_valA = '0; E_valB = '0; E_valC = '0;
        E_dstE = 4'hF; E_dstM = 4'hF; set_CC = 1'b0; m_stat = 4'd1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        m_exp_t x, g;
        @(negedge clk);
        E_stat = v.stat; E_icode = v.icode; E_ifun = v.ifun; E_valA = v.va; E_valB = v.vb;
        E_valC = v.vc; E_dstE = v.dste; E_dstM = 4'hF; set_CC = v.setcc; m_stat = v.mstat;
        x = '{stat: v.x_mstat, icode: v.icode, dste: v.x_dste, chk_val: v.chk_val,
              cnd: v.x_cnd, vale: v.x_vale, cc: v.x_cc};
        sbq.push_back(x);
        #1;
        chk($sformatf("v%0d e_busy", idx), {63'd0, e_busy}, 64'd0);
        chk($sformatf("v%0d e_Cnd", idx), {63'd0, e_Cnd}, {63'd0, v.x_cnd});
        chk($sformatf("v%0d e_dstE", idx), {60'd0, e_dstE}, {60'd0, v.x_dste});
        if (v.chk_val) chk($sformatf("v%0d e_valE", idx), e_valE, v.x_vale);
        @(posedge clk);
        #1;
        g = sbq.pop_front();
        chk($sformatf("v%0d M_stat", idx), {60'd0, M_stat}, {60'd0, g.stat});
        chk($sformatf("v%0d M_icode", idx), {60'd0, M_icode}, {60'd0, g.icode});
        chk($sformatf("v%0d M_Cnd", idx), {63'd0, M_Cnd}, {63'd0, g.cnd});
        chk($sformatf("v%0d M_dstE", idx), {60'd0, M_dstE}, {60'd0, g.dste});
        if (g.chk_val) chk($sformatf("v%0d M_valE", idx), M_valE, g.vale);
        chk($sformatf("v%0d CC", idx), {61'd0, CC}, {61'd0, g.cc});
    endtask

    task automatic mul64(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] xv, input logic [2:0] xcc, input string nm);
        m_exp_t x, g;
        int busy_n;
        @(negedge clk);
        set_nop();
        E_icode = 4'h6; E_ifun = 4'd4; E_valA = a; E_valB = b; E_dstE = 4'd5; set_CC = 1'b1;
        x = '{stat: 4'd1, icode: 4'h6, dste: 4'd5, chk_val: 1'b1, cnd: 1'b0, vale: xv, cc: xcc};
        sbq.push_back(x);
        busy_n = 0;
        #1;
        while (e_busy && busy_n < 8) begin
            busy_n++;
            @(posedge clk);
            #1;
            chk({nm, " bubble M_icode"}, {60'd0, M_icode}, 64'd1);
            chk({nm, " bubble M_dstE"}, {60'd0, M_dstE}, 64'hF);
        end
        chk({nm, " busy cycles"}, 64'(busy_n), 64'd3);
        chk({nm, " e_valE"}, e_valE, xv);
        @(posedge clk);
        #1;
        g = sbq.pop_front();
        chk({nm, " M_icode"}, {60'd0, M_icode}, {60'd0, g.icode});
        chk({nm, " M_valE"}, M_valE, g.vale);
        chk({nm, " M_dstE"}, {60'd0, M_dstE}, {60'd0, g.dste});
        chk({nm, " CC"}, {61'd0, CC}, {61'd0, g.cc});
        set_nop();
    endtask

    initial begin
        // stat icode ifun valA valB valC dstE setCC m_stat chkval | valE Cnd dstE M_stat CC
        vt[0]  = '{1, 2, 0, 42, 0, 0, 3, 0, 1, 1, 42, 1, 3, 1, 3'b100};
        vt[1]  = '{1, 6, 0, 10, 20, 0, 2, 1, 1, 1, 30, 1, 2, 1, 3'b000};
        vt[2]  = '{1, 6, 1, 5, 5, 0, 2, 1, 1, 1, 0, 0, 2, 1, 3'b100};
        vt[3]  = '{1, 2, 1, 7, 0, 0, 4, 0, 1, 1, 7, 1, 4, 1, 3'b100};
        vt[4]  = '{1, 6, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 2, 1, 1, 1,
                   64'h8000_0000_0000_0000, 1, 2, 1, 3'b011};
        vt[5]  = '{1, 2, 3, 5, 0, 0, 4, 0, 1, 1, 5, 0, 4'hF, 1, 3'b011};
        vt[6]  = '{1, 6, 0, 1, 1, 0, 2, 1, 3, 1, 2, 1, 2, 1, 3'b011};
        vt[7]  = '{1, 6, 2, 64'hF0, 64'h3C, 0, 2, 1, 1, 1, 64'h30, 0, 2, 1, 3'b000};
        vt[8]  = '{1, 6, 3, 64'hFF, 64'hFF, 0, 2, 1, 1, 1, 0, 0, 2, 1, 3'b100};
        vt[9]  = '{1, 3, 0, 0, 999, 64'h1234, 6, 0, 1, 1, 64'h1234, 1, 6, 1, 3'b100};
        vt[10] = '{1, 4'hA, 0, 0, 64'h100, 0, 4, 0, 1, 1, 64'hF8, 1, 4, 1, 3'b100};
        vt[11] = '{1, 4'hB, 0, 0, 64'h100, 0, 4, 0, 1, 1, 64'h108, 1, 4, 1, 3'b100};
        vt[12] = '{1, 6, 5, 3, 4, 0, 2, 1, 1, 0, 0, 1, 2, 4, 3'b100};
        vt[13] = '{1, 7, 6, 0, 0, 0, 4'hF, 0, 1, 0, 0, 0, 4'hF, 1, 3'b100};
        vt[14] = '{3, 6, 0, 0, 5, 0, 2, 1, 1, 1, 5, 1, 2, 3, 3'b100};
        vt[15] = '{1, 6, 1, 1, 64'h8000_0000_0000_0000, 0, 2, 1, 1, 1,
                   64'h7FFF_FFFF_FFFF_FFFF, 1, 2, 1, 3'b001};
        vt[16] = '{1, 7, 2, 0, 0, 0, 4'hF, 0, 1, 0, 0, 1, 4'hF, 1, 3'b001};

        set_nop();
        W_stat = 4'd1; M_bubble = 1'b0;
        s_icode = 4'h1; s_ifun = 4'd0; s_valA = '0; s_valB = '0; s_valC = '0;
        s_set_CC = 1'b0; s_bubble = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst M_stat", {60'd0, M_stat}, 64'd1);
        chk("rst M_icode", {60'd0, M_icode}, 64'd1);
        chk("rst M_dstE", {60'd0, M_dstE}, 64'hF);
        chk("rst M_dstM", {60'd0, M_dstM}, 64'hF);
        chk("rst M_Cnd", {63'd0, M_Cnd}, 64'd0);
        chk("rst M_valE", M_valE, 64'd0);
        chk("rst M_valA", M_valA, 64'd0);
        chk("rst CC", {61'd0, CC}, 64'd4);
        chk("rst e_busy", {63'd0, e_busy}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) apply(vt[i], i);

        mul64(64'd7, 64'd6, 64'd42, 3'b000, "mul 7*6");
        mul64(64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 3'b101, "mul 2^32*2^32");

        // M_bubble on the second MULQ cycle
        @(negedge clk);
        E_icode = 4'h6; E_ifun = 4'd4; E_valA = 64'd5; E_valB = 64'd5; set_CC = 1'b1;
        @(posedge clk);
        @(negedge clk);
        M_bubble = 1'b1;
        @(posedge clk);
        #1;
        set_nop();
        M_bubble = 1'b0;
        #1;
        chk("abort bubble e_busy", {63'd0, e_busy}, 64'd0);
        chk("abort bubble M_icode", {60'd0, M_icode}, 64'd1);
        chk("abort bubble CC", {61'd0, CC}, 64'd5);
        mul64(64'd3, 64'd3, 64'd9, 3'b000, "mul 3*3 after bubble");

        // async reset on the second MULQ cycle
        @(negedge clk);
        E_icode = 4'h6; E_ifun = 4'd4; E_valA = 64'd5; E_valB = 64'd5; set_CC = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort rst M_icode", {60'd0, M_icode}, 64'd1);
        chk("abort rst CC", {61'd0, CC}, 64'd4);
        set_nop();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort rst e_busy", {63'd0, e_busy}, 64'd0);
        mul64(64'd3, 64'd3, 64'd9, 3'b000, "mul 3*3 after reset");

        // 16-bit, MUL_LAT=2
        chk("s rst CC", {61'd0, s_CC}, 64'd4);
        @(negedge clk);
        s_icode = 4'h6; s_ifun = 4'd3; s_valA = 16'hFFFF; s_valB = 16'h00FF; s_set_CC = 1'b1;
        #1;
        chk("s xor e_valE", {48'd0, s_e_valE}, 64'hFF00);
        @(posedge clk);
        #1;
        chk("s xor M_valE", {48'd0, s_M_valE}, 64'hFF00);
        chk("s xor CC", {61'd0, s_CC}, 64'd2);
        @(negedge clk);
        s_ifun = 4'd4; s_valA = 16'h0100; s_valB = 16'h0100;
        #1;
        chk("s mul busy", {63'd0, s_e_busy}, 64'd1);
        @(posedge clk);
        #1;
        chk("s mul bubble M_icode", {60'd0, s_M_icode}, 64'd1);
        chk("s mul last busy", {63'd0, s_e_busy}, 64'd0);
        chk("s mul e_valE", {48'd0, s_e_valE}, 64'd0);
        @(posedge clk);
        #1;
        s_icode = 4'h1; s_ifun = 4'd0; s_set_CC = 1'b0;
        chk("s mul M_icode", {60'd0, s_M_icode}, 64'd6);
        chk("s mul M_valE", {48'd0, s_M_valE}, 64'd0);
        chk("s mul CC", {61'd0, s_CC}, 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
